// File: rtl/adder_share_ctrl.sv
// rtl/adder_share_ctrl.sv - round-robin sharing of one external 4-bit adder by two requesters; ADDER_SHARE_OVF_CNT_EN adds ovf_count[7:0]
module adder_share_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    output logic       gnt0,
    input  logic       req1,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    output logic       gnt1,
    output logic [3:0] add_a,
    output logic [3:0] add_b,
    input  logic [3:0] add_sum,
    input  logic       add_cout,
    input  logic       add_ovf,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic       resp_id,
    output logic [3:0] resp_sum,
    output logic       resp_cout,
    output logic       resp_ovf,
    output logic       busy
`ifdef ADDER_SHARE_OVF_CNT_EN
    ,
    output logic [7:0] ovf_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Tie goes to the requester that was not served last; last resets to 1
    // so requester 0 wins the first tie.
    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        case (state)
            IDLE: begin
                gnt0 = req0 & (~req1 | last);
                gnt1 = req1 & ~gnt0;
                if (gnt0 | gnt1) begin
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    // Operands stay on the adder until the next grant so its gate-delayed
    // outputs are never disturbed while settling or while a response waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a      <= 4'd0;
            add_b      <= 4'd0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_sum   <= 4'd0;
            resp_cout  <= 1'b0;
            resp_ovf   <= 1'b0;
            cnt        <= 4'd0;
            last       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt0 | gnt1) begin
                        add_a   <= gnt1 ? a1 : a0;
                        add_b   <= gnt1 ? b1 : b0;
                        resp_id <= gnt1;
                        last    <= gnt1;
                        cnt     <= CNT_LOAD;
                    end
                end
                DRIVE: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        resp_sum   <= add_sum;
                        resp_cout  <= add_cout;
                        resp_ovf   <= add_ovf;
                        resp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ADDER_SHARE_OVF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count <= 8'd0;
        end else if (resp_valid && resp_ready && resp_ovf && (ovf_count != 8'hFF)) begin
            ovf_count <= ovf_count + 8'd1;
        end
    end
`endif

endmodule
